shift_reg_deser: RTL

//  Serial-to-parallel receiver; the far end of the shift_reg serial path.

---
 rtl/shift_reg_deser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/shift_reg_deser.sv
// Serial-to-parallel receiver with a one-deep valid/ready output holding register.
// Optional even-parity bit per frame when PARITY_CHECK_EN is defined.
module shift_reg_deser #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             msb_first,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             par_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] shifted, word;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dir, dir_nxt, dir_use;
  logic             valid_nxt, ovr_nxt, busy_nxt;
  logic             done, pop;
`ifdef PARITY_CHECK_EN
  logic             pbit, perr_q, perr_nxt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      dir     <= 1'b0;
      q_out   <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
      busy    <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= cnt_nxt;
      dir     <= dir_nxt;
      q_out   <= q_nxt;
      q_valid <= valid_nxt;
      overrun <= ovr_nxt;
      busy    <= busy_nxt;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_nxt;
`endif
    end
  end

  // Next-state, shifting and output-register handshake
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    dir_nxt   = dir;
    q_nxt     = q_out;
    valid_nxt = q_valid;
    ovr_nxt   = overrun;
    done      = 1'b0;
    word      = shreg;
`ifdef PARITY_CHECK_EN
    pbit      = 1'b0;
    perr_nxt  = perr_q;
`endif
    // Direction comes from the live input only on the first bit of a frame
    dir_use   = (state == IDLE) ? msb_first : dir;
    shifted   = dir_use ? {shreg[WIDTH-2:0], s_in} : {s_in, shreg[WIDTH-1:1]};
    pop       = q_valid & q_ready;

    case (state)
      IDLE: begin
        if (s_en) begin
          shreg_nxt = shifted;
          dir_nxt   = msb_first;
          cnt_nxt   = CNT_W'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (s_en) begin
          shreg_nxt = shifted;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            cnt_nxt   = CNT_W'(WIDTH);
            state_nxt = PARITY;
`else
            done      = 1'b1;
            word      = shifted;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (s_en) begin
          done      = 1'b1;
          word      = shreg;
          pbit      = ^{shreg, s_in};
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (pop) valid_nxt = 1'b0;

    // A finished word loads only if the holding register is free or draining now
    if (done) begin
      if (!q_valid || q_ready) begin
        q_nxt     = word;
        valid_nxt = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_nxt  = pbit;
`endif
      end else begin
        ovr_nxt = 1'b1;
      end
    end

    if (clr) begin
      state_nxt = IDLE;
      shreg_nxt = '0;
      cnt_nxt   = '0;
      dir_nxt   = 1'b0;
      q_nxt     = '0;
      valid_nxt = 1'b0;
      ovr_nxt   = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_nxt  = 1'b0;
`endif
    end

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef PARITY_CHECK_EN
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

endmodule
